// File: rtl/uart_alu_interface_pkg.sv
// Shared types and defaults for the UART <-> ALU command sequencer.
package uart_alu_interface_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_e;

endpackage

// File: rtl/uart_alu_timeout.sv
// Saturating idle counter; expire_o flags an idle cycle once the count has reached TIMEOUT.
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT = 2**20,
  parameter int          TO_BITS = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] TO_MAX = TO_BITS'(TIMEOUT);

  logic [TO_BITS-1:0] cnt_q;

  // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != TO_MAX)) begin
      cnt_q <= cnt_q + TO_BITS'(1);
    end
  end

  // A zero TIMEOUT never expires; a pop in the same cycle takes priority in the FSM.
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == TO_MAX);

endmodule

// File: rtl/uart_alu_interface.sv
// Command sequencer: pops A, B, opcode from the RX FIFO, registers the ALU result and
// pushes it to the TX FIFO; a stalled partial frame is dropped after an idle timeout.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int          DBIT    = DBIT_DEF,
  parameter int          NB_OP   = NB_OP_DEF,
  parameter int unsigned TIMEOUT = 2**20,
  parameter int          TO_BITS = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_op,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_busy,
  output logic             o_timeout
);

  state_e             state_q;
  logic [DBIT-1:0]    data_a_q, data_b_q, result_q, w_data_q;
  logic [NB_OP-1:0]   op_q;
  logic               rd_q, wr_q, busy_q, timeout_q;

  logic to_active, pop, expire;

  assign to_active = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // While a pop strobe is in flight the FIFO head is still the byte just taken.
  assign pop = (state_q == WAIT_A || to_active) && !rx_empty && !rd_q;

  uart_alu_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!to_active || pop),
    .en_i     (to_active && rx_empty),
    .expire_o (expire)
  );

  // NOTE: operand/result registers are reset too, so every output reads 0 straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_A;
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      result_q  <= '0;
      w_data_q  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        WAIT_A: if (pop) begin
          data_a_q <= r_data;
          rd_q     <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= WAIT_B;
        end
        WAIT_B: if (pop) begin
          data_b_q <= r_data;
          rd_q     <= 1'b1;
          state_q  <= WAIT_OP;
        end else if (expire) begin
          timeout_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= WAIT_A;
        end
        WAIT_OP: if (pop) begin
          op_q    <= r_data[NB_OP-1:0];
          rd_q    <= 1'b1;
          state_q <= EXEC;
        end else if (expire) begin
          timeout_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= WAIT_A;
        end
        EXEC: begin
          result_q <= i_alu_result;
          state_q  <= SEND;
        end
        SEND: if (!tx_full) begin
          w_data_q <= result_q;
          wr_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= WAIT_A;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign rd_uart   = rd_q;
  assign wr_uart   = wr_q;
  assign w_data    = w_data_q;
  assign o_data_a  = data_a_q;
  assign o_data_b  = data_b_q;
  assign o_op      = op_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomised frame-level bench: FIFO model on the RX side, result scoreboard on the TX side.
module tb_uart_alu_interface;

  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 100;
  localparam int TO_BITS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_empty;
  logic [DBIT-1:0]  r_data;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [DBIT-1:0]  w_data;
  logic [DBIT-1:0]  o_data_a, o_data_b;
  logic [NB_OP-1:0] o_op;
  logic [DBIT-1:0]  i_alu_result;
  logic             o_busy, o_timeout;

  uart_alu_interface #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .o_data_a(o_data_a),
    .o_data_b(o_data_b), .o_op(o_op), .i_alu_result(i_alu_result), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int rd_total = 0, wr_total = 0, to_total = 0;
  int idle = 0, to_idle = -1;
  int cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;

  task automatic drive_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic push_frame(logic [7:0] a, logic [7:0] b, logic [7:0] op_byte);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op_byte);
    exp_q.push_back(alu_ref(a, b, op_byte[5:0]));
    drive_rx();
  endtask

  // One clock: sample outputs on the falling edge, retire FIFO traffic after the rising edge.
  task automatic tick();
    logic s_rd, s_wr, s_to, s_empty, underflow;
    logic [7:0] s_w, exp_w;
    @(negedge clk);
    s_rd = rd_uart; s_wr = wr_uart; s_w = w_data; s_to = o_timeout; s_empty = rx_empty;
    cyc++;
    check("rd_wr_exclusive", 32'(s_rd & s_wr), 0);
    if (s_empty) idle++;
    if (s_to) begin
      to_total++;
      to_idle = idle;
    end
    if (s_wr) begin
      wr_total++;
      last_wr_cyc = cyc;
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("w_data", s_w, exp_w);
      end
    end
    @(posedge clk);
    #1;
    if (s_rd) begin
      rd_total++;
      last_rd_cyc = cyc;
      idle = 0;
      underflow = (rx_q.size() == 0);
      check("rd_on_nonempty", 32'(underflow), 0);
      if (!underflow) void'(rx_q.pop_front());
    end
    drive_rx();
  endtask

  task automatic wait_wr(string tag, int n, int budget);
    int target;
    target = wr_total + n;
    for (int i = 0; i < budget && wr_total < target; i++) tick();
    check(tag, 32'(wr_total >= target), 1);
  endtask

  task automatic wait_rd(string tag, int n, int budget);
    int target;
    target = rd_total + n;
    for (int i = 0; i < budget && rd_total < target; i++) tick();
    check(tag, 32'(rd_total >= target), 1);
  endtask

  logic [5:0] ops[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

  initial begin
    int rd0, wr0, to0;
    reset = 1'b1; tx_full = 1'b0;
    drive_rx();
    #2;
    check("rst_rd", rd_uart, 0);   check("rst_wr", wr_uart, 0);
    check("rst_wdata", w_data, 0); check("rst_busy", o_busy, 0);
    check("rst_a", o_data_a, 0);   check("rst_op", o_op, 0);
    #20 reset = 1'b0;
    repeat (2) tick();

    // Basic ADD frame, with opcode-capture to push latency.
    rd0 = rd_total;
    push_frame(8'h05, 8'h03, 8'h20);
    wait_wr("t1_done", 1, 60);
    check("t1_rd_count", rd_total - rd0, 3);
    check("t1_a", o_data_a, 8'h05);
    check("t1_b", o_data_b, 8'h03);
    check("t1_op", o_op, 6'h20);
    check("t1_latency", last_wr_cyc - last_rd_cyc, 2);
    tick();

    // TX full stalls SEND well past the timeout window.
    tx_full = 1'b1;
    wr0 = wr_total; to0 = to_total;
    push_frame(8'h0F, 8'h01, 8'h22);
    repeat (150) tick();
    check("t2_no_wr", wr_total - wr0, 0);
    check("t2_busy", o_busy, 1);
    check("t2_no_timeout", to_total - to0, 0);
    tx_full = 1'b0;
    wait_wr("t2_done", 1, 10);
    tick();
    check("t2_busy_fall", o_busy, 0);

    // Partial frame is discarded after the idle timeout.
    wr0 = wr_total; to0 = to_total;
    rx_q.push_back(8'h11);
    drive_rx();
    for (int i = 0; i < TIMEOUT + 20 && to_total == to0; i++) tick();
    check("t3_timeout_seen", to_total - to0, 1);
    check("t3_timeout_window", 32'(to_idle >= TIMEOUT && to_idle <= TIMEOUT + 3), 1);
    check("t3_busy", o_busy, 0);
    check("t3_no_wr", wr_total - wr0, 0);
    push_frame(8'h02, 8'h02, 8'h20);
    wait_wr("t3_next_frame", 1, 60);

    // Asynchronous reset while waiting for the opcode.
    rx_q.push_back(8'h33);
    rx_q.push_back(8'h44);
    drive_rx();
    wait_rd("t4_two_pops", 2, 20);
    repeat (3) tick();
    check("t4_busy_before", o_busy, 1);
    reset = 1'b1;
    #1;
    check("t4_rst_busy", o_busy, 0); check("t4_rst_a", o_data_a, 0);
    check("t4_rst_b", o_data_b, 0);  check("t4_rst_wdata", w_data, 0);
    check("t4_rst_rd", rd_uart, 0);  check("t4_rst_to", o_timeout, 0);
    #2 reset = 1'b0;
    tick();
    push_frame(8'h07, 8'h09, 8'h20);
    wait_wr("t4_after_reset", 1, 60);

    // Six random frames preloaded back to back.
    rd0 = rd_total;
    for (int f = 0; f < 6; f++) begin
      logic [7:0] op_byte;
      op_byte = {2'($urandom), ops[$urandom_range(0, 5)]};
      push_frame(8'($urandom), 8'($urandom), op_byte);
    end
    wait_wr("t5_six_results", 6, 400);
    check("t5_rd_count", rd_total - rd0, 18);
    check("t5_fifo_drained", rx_q.size(), 0);

    // Byte B arrives on the cycle the idle count has reached TIMEOUT.
    to0 = to_total;
    rx_q.push_back(8'h0A);
    drive_rx();
    wait_rd("t6_pop_a", 1, 20);
    for (int i = 0; i < TIMEOUT + 20 && idle < TIMEOUT && to_total == to0; i++) tick();
    check("t6_idle_reached", idle, TIMEOUT);
    rx_q.push_back(8'h06);
    drive_rx();
    wait_rd("t6_pop_b", 1, 5);
    check("t6_no_timeout", to_total - to0, 0);
    rx_q.push_back(8'h26);
    exp_q.push_back(alu_ref(8'h0A, 8'h06, 6'h26));
    drive_rx();
    wait_wr("t6_done", 1, 40);
    check("t6_no_timeout_end", to_total - to0, 0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("total_timeouts", to_total, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
